// File: rtl/hazard_ctrl_unit.sv
`timescale 1ns/1ps
// Pipeline hazard controller: nearest-first RAW forwarding, load-use and branch
// handling, multi-cycle execute stall FSM and saturating stall/flush counters.
module hazard_ctrl_unit #(
    parameter int ADDRESSWIDTH = 4,
    parameter int FWDSTAGES    = 2,
    parameter int MCYCLES      = 4,
    parameter int ZEROREG      = 0,
    parameter int CNTWIDTH     = 16,
    localparam int SELWIDTH    = $clog2(FWDSTAGES + 1)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [ADDRESSWIDTH-1:0]           reg1AddressD,
    input  logic [ADDRESSWIDTH-1:0]           reg2AddressD,
    input  logic [ADDRESSWIDTH-1:0]           reg1AddressE,
    input  logic [ADDRESSWIDTH-1:0]           reg2AddressE,
    input  logic [ADDRESSWIDTH-1:0]           regDestinationAddressE,
    input  logic                              writeEnableE,
    input  logic                              resultSelectorWBE,
    input  logic                              takeBranchE,
    input  logic                              multiCycleE,
    input  logic [FWDSTAGES*ADDRESSWIDTH-1:0] destAddrFwd,
    input  logic [FWDSTAGES-1:0]              writeEnableFwd,
    output logic [SELWIDTH-1:0]               data1ForwardSelectorE,
    output logic [SELWIDTH-1:0]               data2ForwardSelectorE,
    output logic                              stallF,
    output logic                              stallD,
    output logic                              stallE,
    output logic                              flushD,
    output logic                              flushE,
    output logic                              flushM,
    output logic                              execBusy,
    output logic [CNTWIDTH-1:0]               stallCount,
    output logic [CNTWIDTH-1:0]               flushCount
);

    typedef enum logic {
        RUN    = 1'b0,
        EXBUSY = 1'b1
    } stateT;

    stateT               r_state;
    stateT               w_stateNext;
    logic [7:0]          r_cnt;
    logic [7:0]          w_cntNext;
    logic                r_done;
    logic                w_doneNext;
    logic [CNTWIDTH-1:0] r_stallCount;
    logic [CNTWIDTH-1:0] r_flushCount;
    logic                w_loadUse;
    logic                w_enterBusy;
    logic                w_branchFlush;
    logic [SELWIDTH-1:0] w_sel1;
    logic [SELWIDTH-1:0] w_sel2;

    // Address 0 never matches when it is the hardwired zero register.
    function automatic logic addrMatch(input logic [ADDRESSWIDTH-1:0] a,
                                       input logic [ADDRESSWIDTH-1:0] b);
        return (a == b) && !((ZEROREG != 0) && (a == '0));
    endfunction

    // Scan from the farthest stage inward so the nearest match overwrites.
    function automatic logic [SELWIDTH-1:0] fwdSelect(
        input logic [ADDRESSWIDTH-1:0]           src,
        input logic [FWDSTAGES*ADDRESSWIDTH-1:0] dest,
        input logic [FWDSTAGES-1:0]              we
    );
        logic [SELWIDTH-1:0] sel;
        sel = '0;
        for (int k = FWDSTAGES; k >= 1; k--) begin
            if (we[k-1] && addrMatch(dest[(k-1)*ADDRESSWIDTH +: ADDRESSWIDTH], src)) begin
                sel = SELWIDTH'(k);
            end
        end
        return sel;
    endfunction

    assign w_sel1 = fwdSelect(reg1AddressE, destAddrFwd, writeEnableFwd);
    assign w_sel2 = fwdSelect(reg2AddressE, destAddrFwd, writeEnableFwd);

    assign w_loadUse = resultSelectorWBE && writeEnableE &&
                       (addrMatch(regDestinationAddressE, reg1AddressD) ||
                        addrMatch(regDestinationAddressE, reg2AddressD));
    assign w_branchFlush = (r_state == RUN) && takeBranchE;
    assign w_enterBusy   = (r_state == RUN) && multiCycleE && !takeBranchE && !r_done;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_done  <= w_doneNext;
        end
    end

    // done lives for exactly the one RUN cycle after EXBUSY, blocking re-entry.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_doneNext  = r_done;
        case (r_state)
            RUN: begin
                w_doneNext = 1'b0;
                if (w_enterBusy) begin
                    w_stateNext = EXBUSY;
                    w_cntNext   = 8'(MCYCLES - 2);
                end
            end
            EXBUSY: begin
                if (r_cnt == 8'd0) begin
                    w_stateNext = RUN;
                    w_doneNext  = 1'b1;
                end else begin
                    w_cntNext = r_cnt - 8'd1;
                end
            end
        endcase
    end

    always_comb begin
        stallF                = 1'b0;
        stallD                = 1'b0;
        stallE                = 1'b0;
        flushD                = 1'b0;
        flushE                = 1'b0;
        flushM                = 1'b0;
        execBusy              = (r_state == EXBUSY);
        data1ForwardSelectorE = w_sel1;
        data2ForwardSelectorE = w_sel2;
        if (!reset) begin
            flushD                = 1'b1;
            flushE                = 1'b1;
            flushM                = 1'b1;
            execBusy              = 1'b0;
            data1ForwardSelectorE = '0;
            data2ForwardSelectorE = '0;
        end else if (r_state == EXBUSY) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (takeBranchE) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (w_loadUse && !w_enterBusy) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stallCount <= '0;
            r_flushCount <= '0;
        end else begin
            if (stallF && (r_stallCount != '1)) begin
                r_stallCount <= r_stallCount + 1'b1;
            end
            if (w_branchFlush && (r_flushCount != '1)) begin
                r_flushCount <= r_flushCount + 1'b1;
            end
        end
    end

    assign stallCount = r_stallCount;
    assign flushCount = r_flushCount;

endmodule
